// File: rtl/alu_defs.sv
`timescale 1ps/1fs
// Shared ALU definitions: datapath width and opcodes.
// Every gate-level ALU unit sizes its buses from ALU_WIDTH.
package alu_defs;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_SLT = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;

endpackage

// File: rtl/xor_1.sv
`timescale 1ps/1fs
// One-bit XOR cell: r = (a & ~b) | (~a & b).
// Gate primitives keep it alongside the and_1/or_1 cells.
module xor_1 (
  output logic r,
  input  logic a,
  input  logic b
);

  logic na;
  logic nb;
  logic t0;
  logic t1;

  not u_na (na, a);
  not u_nb (nb, b);
  and u_t0 (t0, a, nb);
  and u_t1 (t1, na, b);
  or  u_r  (r, t0, t1);

endmodule

// File: rtl/xor_32.sv
`timescale 1ps/1fs
// Bitwise XOR unit for the ALU: combinational R and zero,
// plus a registered copy R_q with async active-high reset.
module xor_32
  import alu_defs::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  output logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] R_q,
  output logic             zero
);

  // Independent cells, so an unknown input bit only spoils its own result bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor_1 u_bit (
      .r (R[i]),
      .a (A[i]),
      .b (B[i])
    );
  end

  assign zero = ~|R;

  // Registered result; reset clears it without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) R_q <= '0;
    else     R_q <= R;
  end

endmodule

// File: tb/tb_xor_32.sv
`timescale 1ps/1fs
// Randomised scoreboard bench for xor_32.
// Driver pushes expected R_q values; a monitor pops on each clock.
module tb_xor_32;

  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] R;
  logic [31:0] R_q;
  logic        zero;
  logic        clk;
  logic        rst;

  int n_cmp;
  int n_bad;

  logic [31:0] sb[$];
  logic        rst_at_edge;
  logic [31:0] exp_q;

  xor_32 dut (
    .R    (R),
    .A    (A),
    .B    (B),
    .clk  (clk),
    .rst  (rst),
    .R_q  (R_q),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Reference: a result bit is 1 exactly when the operand bits differ.
  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] e;
    for (int i = 0; i < 32; i++) e[i] = (a[i] != b[i]);
    return e;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez);
    A = a;
    B = b;
    #1;
    check("r_dir", R, er);
    check("zero_dir", {31'd0, zero}, {31'd0, ez});
    check("r_q_held", R_q, 32'd0);
    #99;
  endtask

  // Monitor: each clock taken out of reset must show the oldest expected value.
  always @(posedge clk) begin
    rst_at_edge = rst;
    #0.3;
    if (!rst_at_edge && sb.size() > 0) begin
      exp_q = sb.pop_front();
      check("r_q", R_q, exp_q);
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    A = '0;
    B = '0;
    $monitor("t=%0t A=%08h B=%08h R=%08h zero=%b", $time, A, B, R, zero);

    // Reset takes effect before the first clock edge.
    #0.5;
    rst = 1'b1;
    #0.2;
    check("r_q_async_rst", R_q, 32'd0);

    apply(32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0);
    apply(32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    apply(32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0);
    apply(32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1);
    apply(32'h00000001, 32'h00000000, 32'h00000001, 1'b0);
    apply(32'h80000000, 32'h00000000, 32'h80000000, 1'b0);

    // Release reset with a known operand pair.
    @(negedge clk);
    A = 32'h12345678;
    B = 32'h0F0F0F0F;
    rst = 1'b0;
    sb.push_back(32'h1D3B5977);

    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      e = model(a, b);
      A = a;
      B = b;
      sb.push_back(e);
      #0.5;
      check("r_rand", R, e);
      check("zero_rand", {31'd0, zero}, {31'd0, (e == 32'd0)});
    end

    // Async reset between edges while R_q holds a nonzero value.
    @(negedge clk);
    A = 32'hDEADBEEF;
    B = 32'h00000000;
    sb.push_back(32'hDEADBEEF);
    @(posedge clk);
    #0.6;
    check("r_q_pre_rst", R_q, 32'hDEADBEEF);
    rst = 1'b1;
    #0.1;
    check("r_q_mid_rst", R_q, 32'd0);
    check("r_mid_rst", R, 32'hDEADBEEF);
    check("zero_mid_rst", {31'd0, zero}, 32'd0);

    // First edge after release loads the current R.
    @(negedge clk);
    rst = 1'b0;
    A = 32'hCAFEF00D;
    B = 32'h0F0F0F0F;
    sb.push_back(model(32'hCAFEF00D, 32'h0F0F0F0F));

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #0.5;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
